// File: rtl/dadda_pkg.sv
// ---------------------------------------------------------------------------
// dadda_pkg
// Shared constants and elaboration-time helpers for the Dadda multiplier.
//   GUARD_DEFAULT : default number of accumulator guard bits above 2W
//   dadda_height  : Dadda height sequence 2,3,4,6,9,13,19,28,...
//   dadda_levels  : number of reduction levels needed for a WxW product
//   dadda_plan    : per-level, per-column cell plan (heights, FA/HA counts,
//                   carries arriving from the column below)
// ---------------------------------------------------------------------------
package dadda_pkg;

    localparam int GUARD_DEFAULT = 4;

    // Widest product handled by the planner: 2 * 32 columns.
    localparam int MAX_COLS = 64;

    typedef enum int {
        PLAN_HEIGHT,   // column height entering the level
        PLAN_FA,       // full adders placed in the column
        PLAN_HA,       // half adders placed in the column (0 or 1)
        PLAN_CIN       // carries arriving from column j-1 at this level
    } plan_sel_e;

    function automatic int dadda_height(input int i);
        int d;
        d = 2;
        for (int n = 0; n < i; n++) d = (d * 3) / 2;
        return d;
    endfunction

    // Number of heights strictly below w; each one is a reduction level.
    function automatic int dadda_levels(input int w);
        int n;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            if (dadda_height(k) < w) n = k + 1;
        end
        return n;
    endfunction

    // Replays the whole Dadda reduction for a w x w array and reports one
    // quantity for (step, col). step == levels with PLAN_HEIGHT gives the
    // final (<= 2) column height.
    function automatic int dadda_plan(input int w, input int step, input int col,
                                      input plan_sel_e sel);
        int h  [MAX_COLS];
        int nh [MAX_COLS];
        int levels, d, cin, ex, fa, ha, result;
        levels = dadda_levels(w);
        result = 0;
        for (int j = 0; j < MAX_COLS; j++) begin
            h[j]  = (j < w) ? j + 1 : (j < 2 * w) ? 2 * w - 1 - j : 0;
            nh[j] = 0;
        end
        for (int s = 0; s < levels; s++) begin
            d   = dadda_height(levels - 1 - s);
            cin = 0;
            for (int j = 0; j < 2 * w; j++) begin
                // Excess over the target height: each FA removes two bits,
                // an HA removes one, so HA is only used for an odd excess.
                ex = h[j] + cin - d;
                fa = (ex > 0) ? ex / 2 : 0;
                ha = (ex > 0) ? ex % 2 : 0;
                if (s == step && j == col) begin
                    case (sel)
                        PLAN_HEIGHT: result = h[j];
                        PLAN_FA:     result = fa;
                        PLAN_HA:     result = ha;
                        default:     result = cin;
                    endcase
                end
                nh[j] = h[j] + cin - 2 * fa - ha;
                cin   = fa + ha;
            end
            for (int j = 0; j < MAX_COLS; j++) h[j] = nh[j];
        end
        if (step == levels && sel == PLAN_HEIGHT) result = h[col];
        return result;
    endfunction

endpackage

// File: rtl/dadda_tree.sv
// ---------------------------------------------------------------------------
// dadda_tree
// Purely combinational unsigned W x W partial-product generation and Dadda
// reduction down to two rows. s + c (mod 2^(2W)) equals a * b.
//   a, b : W-bit unsigned operands
//   s, c : 2W-bit carry-save result rows
// Column bits are kept LSB-packed in col[level][column]; bits above the
// column height are tied to zero.
// ---------------------------------------------------------------------------
module dadda_tree
    import dadda_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] s,
    output logic [2*W-1:0] c
);

    localparam int LEVELS = dadda_levels(W);
    localparam int COLS   = 2 * W;

    // NOTE: these are nets, not variables: every bit is driven by its own
    // continuous assign from a different generate scope, which a net allows.
    wire [W-1:0] col [0:LEVELS][0:COLS-1];
    wire [W-1:0] cy  [0:LEVELS-1][0:COLS-1];

    genvar j, i, k, l;

    // Partial products: column j collects a[i] & b[j-i].
    for (j = 0; j < COLS; j++) begin : g_pp
        localparam int LO = (j >= W) ? j - W + 1 : 0;
        localparam int H0 = dadda_plan(W, 0, j, PLAN_HEIGHT);
        for (i = 0; i < W; i++) begin : g_row
            if (j - i >= 0 && j - i < W) begin : g_bit
                assign col[0][j][i-LO] = a[i] & b[j-i];
            end
        end
        for (k = H0; k < W; k++) begin : g_pad
            assign col[0][j][k] = 1'b0;
        end
    end

    // Each level: FA sums, then the HA sum, then untouched bits, then the
    // carries produced by column j-1 at the same level.
    for (l = 0; l < LEVELS; l++) begin : g_lvl
        for (j = 0; j < COLS; j++) begin : g_col
            localparam int H    = dadda_plan(W, l, j, PLAN_HEIGHT);
            localparam int NFA  = dadda_plan(W, l, j, PLAN_FA);
            localparam int NHA  = dadda_plan(W, l, j, PLAN_HA);
            localparam int CIN  = dadda_plan(W, l, j, PLAN_CIN);
            localparam int USED = 3 * NFA + 2 * NHA;
            localparam int PASS = H - USED;
            localparam int NH   = NFA + NHA + PASS + CIN;

            for (k = 0; k < NFA; k++) begin : g_fa
                assign col[l+1][j][k] = col[l][j][3*k] ^ col[l][j][3*k+1] ^ col[l][j][3*k+2];
                assign cy[l][j][k]    = (col[l][j][3*k] & col[l][j][3*k+1]) |
                                        (col[l][j][3*k+2] & (col[l][j][3*k] ^ col[l][j][3*k+1]));
            end
            if (NHA == 1) begin : g_ha
                assign col[l+1][j][NFA] = col[l][j][USED-2] ^ col[l][j][USED-1];
                assign cy[l][j][NFA]    = col[l][j][USED-2] & col[l][j][USED-1];
            end
            for (k = 0; k < PASS; k++) begin : g_pass
                assign col[l+1][j][NFA+NHA+k] = col[l][j][USED+k];
            end
            if (j > 0) begin : g_cin
                for (k = 0; k < CIN; k++) begin : g_c
                    assign col[l+1][j][NFA+NHA+PASS+k] = cy[l][j-1][k];
                end
            end
            for (k = NH; k < W; k++) begin : g_pad
                assign col[l+1][j][k] = 1'b0;
            end
            for (k = NFA + NHA; k < W; k++) begin : g_cpad
                assign cy[l][j][k] = 1'b0;
            end
        end
    end

    // Carries out of the top column are never consumed: for unsigned W x W
    // the product fits in 2W bits.
    for (j = 0; j < COLS; j++) begin : g_out
        assign s[j] = col[LEVELS][j][0];
        assign c[j] = col[LEVELS][j][1];
    end

endmodule

// File: rtl/dadda_mac_pipe.sv
// ---------------------------------------------------------------------------
// dadda_mac_pipe
// Three-stage pipelined unsigned W x W multiplier with optional accumulate.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready = global advance)
//   a, b                : unsigned operands
//   acc_en, acc_clr     : beat adds into / restarts the accumulator
//   out_valid/out_ready : output handshake
//   p                   : zero-extended product or the new accumulator value
// Stages: S1 operands+flags, S2 carry-save rows+flags, S3 p / accumulator.
// All stages advance together whenever the output slot is free or drained.
// ---------------------------------------------------------------------------
module dadda_mac_pipe
    import dadda_pkg::*;
#(
    parameter  int W     = 12,
    parameter  int GUARD = GUARD_DEFAULT,
    localparam int ACC_W = 2 * W + GUARD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] p
);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         en;
        logic         clr;
    } s1_t;

    typedef struct packed {
        logic [2*W-1:0] s;
        logic [2*W-1:0] c;
        logic           en;
        logic           clr;
    } s2_t;

    logic             adv;
    logic             s1_valid, s2_valid;
    s1_t              s1;
    s2_t              s2;
    logic [2*W-1:0]   tree_s, tree_c;
    logic [2*W-1:0]   prod_sum;
    logic [ACC_W-1:0] prod, acc, acc_sum;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    dadda_tree #(.W(W)) u_tree (
        .a (s1.a),
        .b (s1.b),
        .s (tree_s),
        .c (tree_c)
    );

    // Final carry-propagate add; the 2W-bit sum cannot overflow for WxW.
    assign prod_sum = s2.s + s2.c;
    assign prod     = ACC_W'(prod_sum);
    assign acc_sum  = acc + prod;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage reads the value its predecessor held before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1        <= '0;
            s2        <= '0;
            acc       <= '0;
            p         <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1        <= '{a: a, b: b, en: acc_en, clr: acc_clr};
            s2_valid  <= s1_valid;
            s2        <= '{s: tree_s, c: tree_c, en: s1.en, clr: s1.clr};
            out_valid <= s2_valid;
            // Only a real beat may touch the accumulator; bubbles leave it.
            if (s2_valid) begin
                if (s2.clr) begin
                    acc <= prod;
                    p   <= prod;
                end else if (s2.en) begin
                    acc <= acc_sum;
                    p   <= acc_sum;
                end else begin
                    p   <= prod;
                end
            end
        end
    end

endmodule

// File: tb/tb_dadda_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_dadda_mac_pipe
// Directed checks on a W=12 instance plus a random run on W=4/12/16
// instances sharing one stimulus stream, each against a behavioural model.
// Inputs change on the falling edge; outputs are read 1 time unit later.
// ---------------------------------------------------------------------------
module tb_dadda_mac_pipe;

    logic        clk, reset;
    logic        in_valid, out_ready, acc_en, acc_clr;
    logic [15:0] a, b;

    logic        in_ready4, in_ready12, in_ready16;
    logic        out_valid4, out_valid12, out_valid16;
    logic [11:0] p4;
    logic [27:0] p12;
    logic [35:0] p16;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic        last_acc, last_ir;
    logic [63:0] last_p;
    logic        model_on = 1'b0;
    logic [63:0] got_q[$];
    int          got_cyc[$];
    logic [63:0] exp4[$], exp12[$], exp16[$];
    logic [63:0] macc4, macc12, macc16;
    int          acc_cyc0;

    dadda_mac_pipe #(.W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a[3:0]), .b(b[3:0]), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid4), .out_ready(out_ready), .p(p4)
    );
    dadda_mac_pipe #(.W(12)) dut12 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready12),
        .a(a[11:0]), .b(b[11:0]), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid12), .out_ready(out_ready), .p(p12)
    );
    dadda_mac_pipe #(.W(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid16), .out_ready(out_ready), .p(p16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input int idx, input logic [63:0] exp);
        if (got_q.size() > idx) check(tag, got_q[idx], exp);
        else check({tag, "_missing"}, 64'(got_q.size()), 64'(idx + 1));
    endtask

    // Reference MAC for one width: product, accumulate or restart.
    task automatic model_beat(input int w, input logic [63:0] acc_in,
                              output logic [63:0] acc_out, output logic [63:0] exp);
        logic [63:0] mask, accmask, prod;
        mask    = (64'd1 << w) - 64'd1;
        accmask = (64'd1 << (2 * w + 4)) - 64'd1;
        prod    = (64'(a) & mask) * (64'(b) & mask);
        acc_out = acc_in;
        exp     = prod;
        if (acc_clr) begin
            acc_out = prod;
            exp     = prod;
        end else if (acc_en) begin
            acc_out = (acc_in + prod) & accmask;
            exp     = acc_out;
        end
    endtask

    task automatic model_update();
        logic [63:0] e;
        if (out_valid12 && out_ready) begin
            if (exp12.size() == 0) check("rnd_extra_output", 64'(exp12.size()), 64'd1);
            else begin
                check("rnd_w4",  64'(p4),  exp4.pop_front());
                check("rnd_w12", 64'(p12), exp12.pop_front());
                check("rnd_w16", 64'(p16), exp16.pop_front());
            end
        end
        if (in_valid && in_ready12) begin
            model_beat(4,  macc4,  macc4,  e); exp4.push_back(e);
            model_beat(12, macc12, macc12, e); exp12.push_back(e);
            model_beat(16, macc16, macc16, e); exp16.push_back(e);
        end
    endtask

    // One cycle: drive at the falling edge, observe, wait for the next one.
    task automatic step(input logic v, input logic [15:0] ta, input logic [15:0] tb,
                        input logic en, input logic clr, input logic ordy);
        in_valid  = v;
        a         = ta;
        b         = tb;
        acc_en    = en;
        acc_clr   = clr;
        out_ready = ordy;
        #1;
        last_acc = in_valid && in_ready12;
        last_ir  = in_ready12;
        last_p   = 64'(p12);
        if (last_acc && got_q.size() == 0 && acc_cyc0 < 0) acc_cyc0 = cyc;
        if (out_valid12 && out_ready) begin
            got_q.push_back(64'(p12));
            got_cyc.push_back(cyc);
        end
        if (model_on) model_update();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_cyc.delete();
        acc_cyc0 = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        reset = 1'b0;
        {in_valid, out_ready, acc_en, acc_clr} = 4'b0100;
        a = '0;
        b = '0;
        acc_cyc0 = -1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid12), 64'd0);
        check("reset_p", 64'(p12), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready12), 64'd1);
        @(negedge clk);

        // Back-to-back plain products and latency.
        clear_obs();
        step(1'b1, 16'd3328, 16'd3328, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'd4095, 16'd4095, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'd0,    16'd4095, 1'b0, 1'b0, 1'b1);
        idle(5);
        check("mul_count", 64'(got_q.size()), 64'd3);
        check_q("mul_3328sq", 0, 64'd11075584);
        check_q("mul_4095sq", 1, 64'd16769025);
        check_q("mul_zero",   2, 64'd0);
        if (got_cyc.size() >= 2) begin
            check("mul_latency", 64'(got_cyc[0] - acc_cyc0), 64'd3);
            check("mul_back_to_back", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
        end else check("mul_timing_missing", 64'(got_cyc.size()), 64'd2);

        // MAC sequence.
        clear_obs();
        step(1'b1, 16'd2, 16'd3, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'd4, 16'd5, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd7, 16'd9, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        idle(5);
        check_q("mac_clr",    0, 64'd6);
        check_q("mac_en1",    1, 64'd26);
        check_q("mac_en2",    2, 64'd89);
        check_q("mac_plain",  3, 64'd1);
        check_q("mac_resume", 4, 64'd90);

        // Accumulator wrap at 28 bits.
        clear_obs();
        step(1'b1, 16'd4095, 16'd4095, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 16'd4095, 16'd4095, 1'b1, 1'b0, 1'b1);
        idle(5);
        check("wrap_count", 64'(got_q.size()), 64'd17);
        check_q("wrap_second", 1, 64'd33538050);
        check_q("wrap_final", 16, 64'd16637969);

        // Backpressure: output blocked for 5 cycles with 4 beats issued.
        clear_obs();
        idx = 0;
        for (int t = 0; t < 16; t++) begin
            step(idx < 4, 16'(10 + idx), 16'd3, 1'b0, 1'b0, t >= 8);
            if (last_acc) idx++;
            if (t >= 3 && t <= 7) begin
                check("bp_in_ready_low", 64'(last_ir), 64'd0);
                check("bp_p_stable", last_p, 64'd30);
            end
        end
        check("bp_count", 64'(got_q.size()), 64'd4);
        check_q("bp_beat0", 0, 64'd30);
        check_q("bp_beat1", 1, 64'd33);
        check_q("bp_beat2", 2, 64'd36);
        check_q("bp_beat3", 3, 64'd39);
        clear_obs();
        step(1'b1, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        idle(5);
        check_q("bp_acc_kept", 0, 64'd16637969);

        // Reset with beats in flight and acc = 89.
        clear_obs();
        step(1'b1, 16'd2, 16'd3, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'd4, 16'd5, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd7, 16'd9, 1'b1, 1'b0, 1'b1);
        idle(5);
        check_q("rst_pre_acc", 2, 64'd89);
        clear_obs();
        for (int i = 0; i < 3; i++) step(1'b1, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid12), 64'd0);
        check("rst_p", 64'(p12), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_obs();
        step(1'b1, 16'd3, 16'd3, 1'b1, 1'b0, 1'b1);
        idle(5);
        check("rst_only_new_beat", 64'(got_q.size()), 64'd1);
        check_q("rst_acc_cleared", 0, 64'd9);

        // Random traffic on all three widths against the model.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        macc4 = '0;
        macc12 = '0;
        macc16 = '0;
        model_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 7);
        end
        idle(6);
        check("rnd_drained", 64'(exp12.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
